// File: rtl/video_timing_pkg.sv
// Shared types and raster constants for the video timing controller.
package video_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } vt_state_e;

    // Horizontal raster (pixels). The active width and the porches are
    // top-level parameters that default to these values.
    localparam int H_ACTIVE_DEF = 320;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BP_DEF     = 32;

    // Vertical raster (lines) at 15 kHz. VSync bounds are inclusive.
    localparam int NTSC_V_TOTAL  = 262;
    localparam int NTSC_V_ACTIVE = 240;
    localparam int NTSC_VS_FIRST = 244;
    localparam int NTSC_VS_LAST  = 246;
    localparam int PAL_V_TOTAL   = 312;
    localparam int PAL_V_ACTIVE  = 288;
    localparam int PAL_VS_FIRST  = 292;
    localparam int PAL_VS_LAST   = 294;

    typedef struct packed {
        logic [9:0] active;
        logic [9:0] vs_first;
        logic [9:0] vs_last;
    } v_timing_t;

    // Lines per frame; line doubling doubles every vertical constant.
    function automatic logic [9:0] v_total(input logic pal, input logic sd);
        logic [9:0] t;
        t = pal ? 10'(PAL_V_TOTAL) : 10'(NTSC_V_TOTAL);
        return sd ? (t << 1) : t;
    endfunction

    // Blanking and sync boundaries. Doubling the inclusive sync range keeps
    // both lines of every doubled sync line inside the pulse.
    function automatic v_timing_t v_timing(input logic pal, input logic sd);
        v_timing_t t;
        if (pal) begin
            t.active   = 10'(PAL_V_ACTIVE);
            t.vs_first = 10'(PAL_VS_FIRST);
            t.vs_last  = 10'(PAL_VS_LAST);
        end else begin
            t.active   = 10'(NTSC_V_ACTIVE);
            t.vs_first = 10'(NTSC_VS_FIRST);
            t.vs_last  = 10'(NTSC_VS_LAST);
        end
        if (sd) begin
            t.active   = t.active << 1;
            t.vs_first = t.vs_first << 1;
            t.vs_last  = (t.vs_last << 1) | 10'd1;
        end
        return t;
    endfunction

endpackage

// File: rtl/video_ce_gen.sv
// Pixel clock-enable divider: one enable every 4 clocks, or every 2 when
// line doubling. While clr is high the phase is held so the first clock
// after clr drops carries an enable.
module video_ce_gen (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic div2,
    output logic ce
);

    logic [1:0] cnt_q, cnt_d;

    // Next phase: hold at zero while cleared, otherwise count modulo 2 or 4.
    always_comb begin
        cnt_d = cnt_q + 2'd1;
        if (clr)
            cnt_d = 2'd0;
        else if (cnt_q >= (div2 ? 2'd1 : 2'd3))
            cnt_d = 2'd0;
    end

    // Phase register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= 2'd0;
        else
            cnt_q <= cnt_d;
    end

    assign ce = !clr && (cnt_q == 2'd0);

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: pixel enable, h/v counters, blanking and sync
// strobes, frame counter, with a run/stop FSM that only stops on a frame
// boundary. Video standard and line doubling are latched per frame.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   pal,
    input  logic                   scandouble,
    output logic                   ce_pix,
    output logic                   HBlank,
    output logic                   HSync,
    output logic                   VBlank,
    output logic                   VSync,
    output logic                   de,
    output logic [8:0]             hcount,
    output logic [9:0]             vcount,
    output logic                   new_frame,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
);

    localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] HB_FIRST = 9'(H_ACTIVE);
    localparam logic [8:0] HS_FIRST = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_LAST  = 9'(H_ACTIVE + H_FP + H_SYNC - 1);

    logic [1:0]             rst_sync_q, rst_sync_d;
    vt_state_e              state_q, state_d;
    logic                   pal_q, pal_d, sd_q, sd_d;
    logic [8:0]             hcount_q, hcount_d;
    logic [9:0]             vcount_q, vcount_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   hblank_q, hblank_d, hsync_q, hsync_d;
    logic                   vblank_q, vblank_d, vsync_q, vsync_d;
    logic                   rst_ok, ce, line_end, frame_end;
    logic [9:0]             v_last;
    v_timing_t              vt_nxt;

    // Reset is asserted asynchronously everywhere, but the FSM may only leave
    // IDLE once the release has passed through two flops.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_ok = rst_sync_q[1];

    video_ce_gen u_ce_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state_q == ST_IDLE),
        .div2    (sd_q),
        .ce      (ce)
    );

    // Next-state, counters, per-frame mode latch and strobes for the new position.
    always_comb begin
        state_d     = state_q;
        pal_d       = pal_q;
        sd_d        = sd_q;
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        frame_cnt_d = frame_cnt_q;

        v_last    = v_total(pal_q, sd_q) - 10'd1;
        line_end  = ce && (hcount_q == H_LAST);
        frame_end = line_end && (vcount_q == v_last);

        case (state_q)
            ST_IDLE: begin
                if (run && rst_ok) begin
                    state_d = ST_RUN;
                    pal_d   = pal;
                    sd_d    = scandouble;
                end
            end
            ST_RUN:      if (!run) state_d = frame_end ? ST_IDLE : ST_STOPPING;
            ST_STOPPING: begin
                if (run)
                    state_d = ST_RUN;
                else if (frame_end)
                    state_d = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            hcount_d    = 9'd0;
            vcount_d    = 10'd0;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            // Mode changes only take effect on a frame boundary.
            if (state_d != ST_IDLE) begin
                pal_d = pal;
                sd_d  = scandouble;
            end
        end else if (line_end) begin
            hcount_d = 9'd0;
            vcount_d = vcount_q + 10'd1;
        end else if (ce) begin
            hcount_d = hcount_q + 9'd1;
        end

        if (state_d == ST_IDLE) begin
            hcount_d = 9'd0;
            vcount_d = 10'd0;
        end

        // Strobes are computed from the next counter values so the
        // registered strobes always line up with the registered counters.
        vt_nxt = v_timing(pal_d, sd_d);
        if (state_d == ST_IDLE) begin
            hblank_d = 1'b1;
            hsync_d  = 1'b0;
            vblank_d = 1'b1;
            vsync_d  = 1'b0;
        end else begin
            hblank_d = hcount_d >= HB_FIRST;
            hsync_d  = (hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST);
            vblank_d = vcount_d >= vt_nxt.active;
            vsync_d  = (vcount_d >= vt_nxt.vs_first) && (vcount_d <= vt_nxt.vs_last);
        end
    end

    // All state, including the FSM, with asynchronous reset to idle values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q  <= 2'b00;
            state_q     <= ST_IDLE;
            pal_q       <= 1'b0;
            sd_q        <= 1'b0;
            hcount_q    <= 9'd0;
            vcount_q    <= 10'd0;
            frame_cnt_q <= '0;
            hblank_q    <= 1'b1;
            hsync_q     <= 1'b0;
            vblank_q    <= 1'b1;
            vsync_q     <= 1'b0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            state_q     <= state_d;
            pal_q       <= pal_d;
            sd_q        <= sd_d;
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            frame_cnt_q <= frame_cnt_d;
            hblank_q    <= hblank_d;
            hsync_q     <= hsync_d;
            vblank_q    <= vblank_d;
            vsync_q     <= vsync_d;
        end
    end

    assign ce_pix    = ce;
    assign HBlank    = hblank_q;
    assign HSync     = hsync_q;
    assign VBlank    = vblank_q;
    assign VSync     = vsync_q;
    assign de        = !(hblank_q || vblank_q);
    assign hcount    = hcount_q;
    assign vcount    = vcount_q;
    assign new_frame = ce && (hcount_q == 9'd0) && (vcount_q == 10'd0);
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl. A shrunken-line instance (12 px/line) runs
// whole frames against a raster-position model; a default instance checks
// the 400-pixel line and the mid-line asynchronous reset.
module tb_video_timing_ctrl;

    localparam int HA = 6, HFP = 2, HS = 2, HBP = 2, HT = 12;

    logic clk = 1'b0, reset_n = 1'b0;
    logic run = 1'b0, pal = 1'b0, sd = 1'b0;
    logic run2 = 1'b0, d_pal = 1'b0, d_sd = 1'b0;

    logic s_ce, s_hb, s_hs, s_vb, s_vs, s_de, s_nf, s_busy;
    logic [8:0] s_h;
    logic [9:0] s_v;
    logic [1:0] s_fc;
    logic d_ce, d_hb, d_hs, d_vb, d_vs, d_de, d_nf, d_busy;
    logic [8:0] d_h;
    logic [9:0] d_v;
    logic [15:0] d_fc;

    video_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .FRAME_CNT_W(2)) u_small (
        .clk(clk), .reset_n(reset_n), .run(run), .pal(pal), .scandouble(sd),
        .ce_pix(s_ce), .HBlank(s_hb), .HSync(s_hs), .VBlank(s_vb), .VSync(s_vs), .de(s_de),
        .hcount(s_h), .vcount(s_v), .new_frame(s_nf), .frame_cnt(s_fc), .busy(s_busy));

    video_timing_ctrl u_dflt (
        .clk(clk), .reset_n(reset_n), .run(run2), .pal(d_pal), .scandouble(d_sd),
        .ce_pix(d_ce), .HBlank(d_hb), .HSync(d_hs), .VBlank(d_vb), .VSync(d_vs), .de(d_de),
        .hcount(d_h), .vcount(d_v), .new_frame(d_nf), .frame_cnt(d_fc), .busy(d_busy));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---- raster model: a linear position in the frame plus per-frame mode ----
    function automatic int vtot(bit p, bit s); return (p ? 312 : 262) * (s ? 2 : 1); endfunction
    function automatic int vact(bit p, bit s); return (p ? 288 : 240) * (s ? 2 : 1); endfunction
    function automatic bit vsy(int v, bit p, bit s);
        int k; k = s ? 2 : 1;
        return (v >= (p ? 292 : 244) * k) && (v <= (p ? 295 : 247) * k - 1);
    endfunction

    int m_sync, m_pos, m_gap, m_frames;
    bit m_act, m_pal, m_sd;

    always @(posedge clk or negedge reset_n) begin
        bit ce_m;
        if (!reset_n) begin
            m_sync <= 0; m_act <= 0; m_pos <= 0; m_pal <= 0; m_sd <= 0; m_gap <= 0; m_frames <= 0;
        end else begin
            ce_m = m_act && (m_gap == (m_sd ? 2 : 4));
            if (!m_act) begin
                if (run && m_sync >= 2) begin
                    m_act <= 1; m_pal <= pal; m_sd <= sd; m_pos <= 0; m_gap <= (sd ? 2 : 4);
                end
            end else if (ce_m) begin
                m_gap <= 1;
                if (m_pos == vtot(m_pal, m_sd) * HT - 1) begin
                    m_frames <= m_frames + 1;
                    m_pos <= 0;
                    if (!run) m_act <= 0;
                    else begin m_pal <= pal; m_sd <= sd; end
                end else m_pos <= m_pos + 1;
            end else m_gap <= m_gap + 1;
            if (m_sync < 2) m_sync <= m_sync + 1;
        end
    end

    // Per-cycle comparison of the small instance against the model.
    always @(negedge clk) begin
        int h, v;
        bit cee;
        if (chk_en) begin
            h = m_pos % HT; v = m_pos / HT;
            cee = m_act && (m_gap == (m_sd ? 2 : 4));
            chk("ce_pix", s_ce, cee);
            chk("hcount", s_h, h);
            chk("vcount", s_v, v);
            chk("HBlank", s_hb, !m_act || h >= HA);
            chk("HSync", s_hs, m_act && h >= HA + HFP && h < HA + HFP + HS);
            chk("VBlank", s_vb, !m_act || v >= vact(m_pal, m_sd));
            chk("VSync", s_vs, m_act && vsy(v, m_pal, m_sd));
            chk("de", s_de, m_act && h < HA && v < vact(m_pal, m_sd));
            chk("new_frame", s_nf, cee && m_pos == 0);
            chk("busy", s_busy, m_act);
            chk("frame_cnt", s_fc, m_frames % 4);
        end
    end

    // Frame-level tallies of the small instance for hand-computed pins.
    int cyc = 0, de_acc = 0, vs_acc = 0;
    bit busy_prev = 1'b0;
    int nf_q[$], de_q[$], vs_q[$], bf_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= s_busy;
        if (busy_prev && !s_busy) bf_q.push_back(cyc);
        if (s_nf) begin
            nf_q.push_back(cyc); de_q.push_back(de_acc); vs_q.push_back(vs_acc);
            de_acc <= (s_ce && s_de) ? 1 : 0;
            vs_acc <= 0;
        end else begin
            if (s_ce && s_de) de_acc <= de_acc + 1;
            if (s_ce && s_vs) vs_acc <= vs_acc + 1;
        end
    end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic wait_line(input int line, input int lim);
        int i = 0;
        do begin step(); i++; end while (!(s_v == 10'(line) && s_h == 9'd0) && i < lim);
        chk($sformatf("reach_line_%0d", line), int'(i < lim), 1);
    endtask

    task automatic wait_nf(input string nm, input int lim);
        int i = 0;
        do begin step(); i++; end while (!s_nf && i < lim);
        chk(nm, int'(i < lim), 1);
    endtask

    task automatic chk_rst(input string p, input bit dflt);
        chk({p, "_ce"}, dflt ? d_ce : s_ce, 0);
        chk({p, "_h"}, dflt ? d_h : s_h, 0);
        chk({p, "_v"}, dflt ? d_v : s_v, 0);
        chk({p, "_hb"}, dflt ? d_hb : s_hb, 1);
        chk({p, "_vb"}, dflt ? d_vb : s_vb, 1);
        chk({p, "_hs"}, dflt ? d_hs : s_hs, 0);
        chk({p, "_vs"}, dflt ? d_vs : s_vs, 0);
        chk({p, "_de"}, dflt ? d_de : s_de, 0);
        chk({p, "_nf"}, dflt ? d_nf : s_nf, 0);
        chk({p, "_busy"}, dflt ? d_busy : s_busy, 0);
        chk({p, "_fc"}, dflt ? int'(d_fc) : int'(s_fc), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, i, nce, last, hs0, h, v;
        step();
        chk_en = 1'b1;
        chk_rst("por_d", 1);
        step();
        reset_n = 1'b1;
        run2 = 1'b1;

        // Default 400-pixel line: first enable three clocks after release.
        k = 0;
        do begin step(); k++; end while (!d_ce && k < 20);
        chk("d_first_ce_latency", k, 3);
        chk("d_start_h", d_h, 0); chk("d_start_v", d_v, 0);
        chk("d_start_nf", d_nf, 1); chk("d_start_de", d_de, 1); chk("d_start_busy", d_busy, 1);

        nce = 1; last = 0; hs0 = 0; i = 0;
        while (nce < 601 && i < 3000) begin
            step(); i++;
            if (d_ce) begin
                chk("d_ce_gap", i - last, 4);
                last = i;
                h = nce % 400; v = nce / 400;
                chk("d_hcount", d_h, h);
                chk("d_vcount", d_v, v);
                chk("d_hsync", d_hs, h >= 336 && h <= 367);
                chk("d_hblank", d_hb, h >= 320);
                chk("d_nf", d_nf, 0);
                if (v == 0 && d_hs) hs0++;
                nce++;
            end
        end
        chk("d_reach_h200", nce, 601);
        chk("d_hsync_ce_line0", hs0, 32);
        chk("d_h_before_rst", d_h, 200);

        // Asynchronous reset mid-line, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk_rst("arst_d", 1);
        chk_rst("arst_s", 0);
        step();
        reset_n = 1'b1;
        k = 0;
        do begin step(); k++; end while (!d_ce && k < 20);
        chk("d_restart_latency", k, 3);
        chk("d_restart_h", d_h, 0); chk("d_restart_v", d_v, 0); chk("d_restart_nf", d_nf, 1);
        run2 = 1'b0;

        // Small instance: NTSC frame, PAL requested mid-frame.
        run = 1'b1;
        wait_line(100, 6000);
        pal = 1'b1;
        wait_nf("nf_f2", 14000);
        wait_line(10, 1000);
        pal = 1'b0;
        wait_nf("nf_f3", 16000);
        wait_line(50, 3000);
        run = 1'b0;
        i = 0;
        do begin step(); i++; end while (s_busy && i < 14000);
        chk("stop_to_idle", int'(i < 14000), 1);
        chk("idle_fc", s_fc, 3);
        chk("idle_hb", s_hb, 1); chk("idle_vb", s_vb, 1); chk("idle_de", s_de, 0);

        // Line-doubled frame with a short stop/resume inside it.
        sd = 1'b1;
        run = 1'b1;
        wait_nf("nf_f4", 20);
        wait_line(100, 3000);
        run = 1'b0;
        wait_line(110, 300);
        run = 1'b1;
        wait_nf("nf_f5", 12000);
        chk("fc_wrap", s_fc, 0);

        // Asynchronous reset of the small instance mid-line.
        i = 0;
        do begin step(); i++; end while (s_h != 9'd5 && i < 50);
        chk("reach_h5", int'(i < 50), 1);
        #2 reset_n = 1'b0;
        #1;
        chk_rst("arst2_s", 0);
        step();
        reset_n = 1'b1;
        wait_nf("nf_after_rst", 20);
        chk("rst_restart_h", s_h, 0); chk("rst_restart_v", s_v, 0);
        repeat (20) step();

        // Frame-level pins: periods in clocks, de and VSync enable counts.
        chk("nf_count", int'(nf_q.size() >= 6), 1);
        if (nf_q.size() >= 6 && de_q.size() >= 5 && vs_q.size() >= 5) begin
            chk("period_ntsc", nf_q[1] - nf_q[0], 12576);
            chk("period_pal", nf_q[2] - nf_q[1], 14976);
            chk("period_sd_resume", nf_q[4] - nf_q[3], 12576);
            chk("de_ntsc", de_q[1], 1440);
            chk("de_pal", de_q[2], 1728);
            chk("de_ntsc_stop", de_q[3], 1440);
            chk("de_sd", de_q[4], 2880);
            chk("vs_ntsc", vs_q[1], 36);
            chk("vs_pal", vs_q[2], 36);
            chk("vs_sd", vs_q[4], 72);
        end
        chk("busy_fall_count", int'(bf_q.size() >= 1), 1);
        if (bf_q.size() >= 1 && nf_q.size() >= 3)
            chk("busy_fall_cycle", bf_q[0] - nf_q[2], 12573);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameter: H_ACTIVE, default 320, visible pixels per line.
REQ-002 Parameter: FRAME_CNT_W, default 16, width of frame_cnt.
REQ-003 clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 run  in  1  level request to generate timing.
REQ-006 pal  in  1  0 = NTSC timing, 1 = PAL timing.
REQ-007 scandouble  in  1  1 = 31 kHz line-doubled timing.
REQ-008 ce_pix  out  1  pixel clock enable.
REQ-009 HBlank, HSync, VBlank, VSync  out  1 each  timing strobes, all active high.
REQ-010 de  out  1  ~(HBlank|VBlank).
REQ-011 hcount  out  9  pixel index within line; vcount  out  10  line index within frame.
REQ-012 new_frame  out  1  single-ce_pix pulse at pixel (0,0).
REQ-013 frame_cnt  out  FRAME_CNT_W  completed-frame counter.
REQ-014 busy  out  1  FSM not IDLE.

Function
REQ-015 ce_pix SHALL be high 1 clk in every 4 (scandouble=0) or every 2 (scandouble=1), starting the clk after leaving IDLE.
REQ-016 All counters and strobes SHALL advance only on clk cycles where ce_pix=1.
REQ-017 Horizontal: total 400 pixels; active 0..319, front porch 320..335, HSync 336..367, back porch 368..399; HBlank = hcount>=320.
REQ-018 Vertical NTSC: total 262 lines; active 0..239, VSync 244..246, VBlank = vcount>=240.
REQ-019 Vertical PAL: total 312 lines; active 0..287, VSync 292..294, VBlank = vcount>=288.
REQ-020 scandouble=1 SHALL double every vertical constant (NTSC 524/480/488..493, PAL 624/576/584..589).
REQ-021 hcount SHALL wrap 399->0 and increment vcount; vcount SHALL wrap total-1->0 and increment frame_cnt (modulo 2^FRAME_CNT_W).
REQ-022 pal and scandouble SHALL be sampled only in IDLE->RUN and at each frame wrap; changes mid-frame SHALL have no effect until the next frame.
REQ-023 Strobes SHALL be registered, reflecting hcount/vcount of the same ce_pix cycle.
REQ-024 FSM states: IDLE, RUN, STOPPING.
REQ-025 IDLE->RUN when run=1; counters start at (0,0) with new_frame asserted.
REQ-026 RUN->STOPPING when run=0; STOPPING->RUN when run=1 again, with no counter disturbance.
REQ-027 STOPPING->IDLE at the frame wrap (hcount=399, vcount=total-1, ce_pix=1).
REQ-028 In IDLE: ce_pix=0, counters held at 0, HBlank=VBlank=1, HSync=VSync=0, new_frame=0.
REQ-029 run=0 and frame wrap in the same cycle while in RUN SHALL go directly to IDLE.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, clear the ce divider, hcount, vcount and frame_cnt, and latch pal=0 and scandouble=0.
REQ-031 Output reset values: ce_pix=0, HBlank=1, VBlank=1, HSync=0, VSync=0, de=0, new_frame=0, busy=0.
REQ-032 Reset deassertion SHALL be synchronised inside the block (2-flop) before it releases the FSM.

Structure
REQ-033 Package video_timing_pkg SHALL hold the FSM state enum and all H/V timing constants for NTSC and PAL.
REQ-034 One sub-module, video_ce_gen, SHALL implement the ÷2/÷4 enable divider with a synchronous clear.

Verification
REQ-035 Reset, then run=1, pal=0, scandouble=0 -> ce_pix at 1/4 clk; 400 ce per line; 262 lines; HSync high for exactly 32 ce; VSync high during lines 244..246.
REQ-036 pal toggled 0->1 at line 100 -> current frame ends at 262 lines; next frame is 312 lines with VSync on lines 292..294.
REQ-037 scandouble=1 from start -> ce_pix at 1/2 clk; frame 524 lines; de high for 480 lines × 320 px.
REQ-038 run dropped at line 50 -> busy stays 1 until line 261 px 399, then IDLE with strobe reset values; frame_cnt incremented by 1.
REQ-039 run dropped and restored within one frame -> no discontinuity in hcount/vcount; new_frame period unchanged.
REQ-040 reset_n asserted mid-line (hcount=200) -> outputs take reset values in the same cycle with no clk edge; after release plus run, the frame restarts at (0,0) with new_frame.
